food_place_ctrl: RTL and testbench

FOOD_PLACE_CTRL -- requirements
Module: food_place_ctrl

---
 rtl/food_place_ctrl.sv | 132 +++++++++++++
 tb/tb_food_place_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_place_ctrl.sv
// rtl/food_place_ctrl.sv - picks a free, cell-aligned food position from a random box source
// Retries up to MAX_TRIES candidates, asking the snake occupancy map about each legal one.
module food_place_ctrl #(
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 608,
    parameter int Y_MIN     = 16,
    parameter int Y_MAX     = 448,
    parameter int CELL_LOG2 = 4,
    parameter int MAX_TRIES = 15
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_start,
    input  logic       I_eaten,
    output logic       O_box_drive,
    input  logic [9:0] I_box_x,
    input  logic [9:0] I_box_y,
    output logic       O_occ_req,
    output logic [9:0] O_occ_x,
    output logic [9:0] O_occ_y,
    input  logic       I_occ_ack,
    input  logic       I_occ_hit,
    output logic [9:0] O_food_x,
    output logic [9:0] O_food_y,
    output logic       O_food_valid,
    output logic       O_busy,
    output logic       O_fail,
    output logic [3:0] O_tries
);

    localparam logic [9:0] XMIN_V    = 10'(X_MIN);
    localparam logic [9:0] XMAX_V    = 10'(X_MAX);
    localparam logic [9:0] YMIN_V    = 10'(Y_MIN);
    localparam logic [9:0] YMAX_V    = 10'(Y_MAX);
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);
    localparam logic [3:0] MAX_T     = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_QUERY,
        S_FAIL
    } state_t;

    state_t     state;
    logic [9:0] cand_x;
    logic [9:0] cand_y;
    logic       box_legal;
    logic [3:0] tries_inc;

    function automatic logic is_legal(input logic [9:0] x, input logic [9:0] y);
        return (x >= XMIN_V) && (x <= XMAX_V) && (y >= YMIN_V) && (y <= YMAX_V)
            && ((x & CELL_MASK) == 10'd0) && ((y & CELL_MASK) == 10'd0);
    endfunction

    assign box_legal = is_legal(I_box_x, I_box_y);
    assign tries_inc = O_tries + 4'd1;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state        <= S_IDLE;
            cand_x       <= '0;
            cand_y       <= '0;
            O_food_x     <= '0;
            O_food_y     <= '0;
            O_food_valid <= 1'b0;
            O_fail       <= 1'b0;
            O_tries      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_start || I_eaten) begin
                        state        <= S_DRIVE;
                        O_food_valid <= 1'b0;
                        O_fail       <= 1'b0;
                        O_tries      <= '0;
                    end
                end
                S_DRIVE:  state <= S_WAIT;
                S_WAIT:   state <= S_SAMPLE;
                S_SAMPLE: begin
                    cand_x  <= I_box_x;
                    cand_y  <= I_box_y;
                    O_tries <= tries_inc;
                    // O_tries has already counted this candidate when the limit is compared
                    if (box_legal) begin
                        state <= S_QUERY;
                    end else if (tries_inc == MAX_T) begin
                        state  <= S_FAIL;
                        O_fail <= 1'b1;
                    end else begin
                        state <= S_DRIVE;
                    end
                end
                S_QUERY: begin
                    if (I_occ_ack) begin
                        if (!I_occ_hit) begin
                            O_food_x     <= cand_x;
                            O_food_y     <= cand_y;
                            O_food_valid <= 1'b1;
                            state        <= S_IDLE;
                        end else if (O_tries == MAX_T) begin
                            state  <= S_FAIL;
                            O_fail <= 1'b1;
                        end else begin
                            state <= S_DRIVE;
                        end
                    end
                end
                S_FAIL: begin
                    // Only a new game may leave FAIL; a stray eaten pulse has no food to replace
                    if (I_start) begin
                        state   <= S_DRIVE;
                        O_fail  <= 1'b0;
                        O_tries <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign O_box_drive = (state == S_DRIVE);
    assign O_occ_req   = (state == S_QUERY);
    assign O_occ_x     = cand_x;
    assign O_occ_y     = cand_y;
    assign O_busy      = (state == S_DRIVE) || (state == S_WAIT)
                      || (state == S_SAMPLE) || (state == S_QUERY);

endmodule

// File: tb/tb_food_place_ctrl.sv
// tb/tb_food_place_ctrl.sv - self-checking bench for food_place_ctrl
module tb_food_place_ctrl;

    logic       I_clk = 1'b0;
    logic       I_rst = 1'b1;
    logic       I_start = 1'b0;
    logic       I_eaten = 1'b0;
    logic       O_box_drive;
    logic [9:0] I_box_x = '0;
    logic [9:0] I_box_y = '0;
    logic       O_occ_req;
    logic [9:0] O_occ_x;
    logic [9:0] O_occ_y;
    logic       I_occ_ack = 1'b0;
    logic       I_occ_hit = 1'b0;
    logic [9:0] O_food_x;
    logic [9:0] O_food_y;
    logic       O_food_valid;
    logic       O_busy;
    logic       O_fail;
    logic [3:0] O_tries;

    food_place_ctrl dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_eaten(I_eaten),
        .O_box_drive(O_box_drive), .I_box_x(I_box_x), .I_box_y(I_box_y),
        .O_occ_req(O_occ_req), .O_occ_x(O_occ_x), .O_occ_y(O_occ_y),
        .I_occ_ack(I_occ_ack), .I_occ_hit(I_occ_hit),
        .O_food_x(O_food_x), .O_food_y(O_food_y), .O_food_valid(O_food_valid),
        .O_busy(O_busy), .O_fail(O_fail), .O_tries(O_tries)
    );

    always #5 I_clk = ~I_clk;

    int checks = 0;
    int errors = 0;

    // Scenario: candidate list, and per-query hit/ack-delay lists
    int v_x[$], v_y[$], v_hit[$], v_dly[$];
    int q_x[$], q_y[$], q_hit[$], q_dly[$];
    int exp_food_x = 0, exp_food_y = 0;
    bit in_fail = 0;
    bit spurious_ack = 0;

    int g_drives, g_reqs, g_req_cycles, g_cyc, g_stab_err, g_illegal_req;
    logic [31:0] g_tries_start, g_valid_start;

    typedef struct {
        int x;
        int y;
        bit legal;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit tb_legal(input int x, input int y);
        return x >= 16 && x <= 608 && y >= 16 && y <= 448 && x % 16 == 0 && y % 16 == 0;
    endfunction

    task automatic pad_scenario();
        while (v_x.size() < 15) begin
            v_x.push_back(64);
            v_y.push_back(64);
        end
        while (v_hit.size() < 15) begin
            v_hit.push_back(0);
            v_dly.push_back(0);
        end
    endtask

    task automatic clear_scenario();
        v_x.delete(); v_y.delete(); v_hit.delete(); v_dly.delete();
    endtask

    task automatic model(output bit ok, output int tries, output int reqs, output int cyc,
                         output int fx, output int fy);
        int h = 0;
        ok = 0; tries = 0; reqs = 0; cyc = 0; fx = 0; fy = 0;
        for (int i = 0; i < 15; i++) begin
            tries = i + 1;
            cyc += 3;
            if (tb_legal(v_x[i], v_y[i])) begin
                reqs++;
                cyc += v_dly[h] + 1;
                if (v_hit[h] == 0) begin
                    ok = 1; fx = v_x[i]; fy = v_y[i];
                    break;
                end
                h++;
            end
        end
    endtask

    // Acts as box generator and occupancy map until the DUT goes idle
    task automatic do_place(input bit st, input bit ea, input bit poke_eaten);
        int age = 0;
        int cur_hit = 0, cur_dly = 0;
        logic [9:0] cx = '0, cy = '0;
        g_drives = 0; g_reqs = 0; g_req_cycles = 0; g_cyc = 0; g_stab_err = 0; g_illegal_req = 0;
        q_x = v_x; q_y = v_y; q_hit = v_hit; q_dly = v_dly;
        I_start = st; I_eaten = ea;
        @(negedge I_clk);
        I_start = 0; I_eaten = 0;
        g_tries_start = 32'(O_tries);
        g_valid_start = 32'(O_food_valid);
        while (O_busy && g_cyc < 400) begin
            g_cyc++;
            I_occ_ack = 0; I_occ_hit = 0; I_eaten = 0;
            if (O_box_drive) begin
                g_drives++;
                if (q_x.size() > 0) begin
                    I_box_x = 10'(q_x.pop_front());
                    I_box_y = 10'(q_y.pop_front());
                end else begin
                    I_box_x = 10'd1;
                    I_box_y = 10'd1;
                end
            end
            if (O_occ_req) begin
                g_req_cycles++;
                if (age == 0) begin
                    g_reqs++;
                    cx = O_occ_x; cy = O_occ_y;
                    if (!tb_legal(int'(cx), int'(cy))) g_illegal_req++;
                    cur_hit = (q_hit.size() > 0) ? q_hit.pop_front() : 0;
                    cur_dly = (q_dly.size() > 0) ? q_dly.pop_front() : 0;
                end else if (O_occ_x != cx || O_occ_y != cy) begin
                    g_stab_err++;
                end
                if (poke_eaten && age == 1) I_eaten = 1;
                if (age == cur_dly) begin
                    I_occ_ack = 1; I_occ_hit = cur_hit[0]; age = 0;
                end else begin
                    age++;
                end
            end else if (spurious_ack && $urandom_range(0, 2) == 0) begin
                I_occ_ack = 1; I_occ_hit = 0;
            end
            @(negedge I_clk);
        end
        I_occ_ack = 0; I_occ_hit = 0; I_eaten = 0;
        check("place_done", 32'(O_busy), 0);
    endtask

    task automatic run_case(input string tag, input bit st, input bit ea, input bit poke);
        bit ok;
        int tries, reqs, cyc, fx, fy;
        pad_scenario();
        model(ok, tries, reqs, cyc, fx, fy);
        do_place(st, ea, poke);
        check({tag, "_tries_clr"}, g_tries_start, 0);
        check({tag, "_valid_clr"}, g_valid_start, 0);
        check({tag, "_fail"}, 32'(O_fail), 32'(!ok));
        check({tag, "_valid"}, 32'(O_food_valid), 32'(ok));
        check({tag, "_tries"}, 32'(O_tries), 32'(tries));
        check({tag, "_drives"}, g_drives, tries);
        check({tag, "_reqs"}, g_reqs, reqs);
        check({tag, "_cycles"}, g_cyc, cyc);
        check({tag, "_stable"}, g_stab_err, 0);
        check({tag, "_legal_req"}, g_illegal_req, 0);
        if (ok) begin
            exp_food_x = fx;
            exp_food_y = fy;
        end
        check({tag, "_food_x"}, 32'(O_food_x), 32'(exp_food_x));
        check({tag, "_food_y"}, 32'(O_food_y), 32'(exp_food_y));
        in_fail = !ok;
    endtask

    vec_t table_v[10];

    initial begin
        table_v[0] = '{32, 48, 1};
        table_v[1] = '{16, 16, 1};
        table_v[2] = '{608, 448, 1};
        table_v[3] = '{624, 448, 0};
        table_v[4] = '{33, 48, 0};
        table_v[5] = '{0, 48, 0};
        table_v[6] = '{608, 464, 0};
        table_v[7] = '{16, 0, 0};
        table_v[8] = '{600, 400, 0};
        table_v[9] = '{592, 432, 1};

        repeat (2) @(negedge I_clk);
        I_start = 1; I_eaten = 1;
        @(negedge I_clk);
        check("rst_dominates_busy", 32'(O_busy), 0);
        I_rst = 0; I_start = 0; I_eaten = 0;
        check("rst_food_x", 32'(O_food_x), 0);
        check("rst_food_y", 32'(O_food_y), 0);
        check("rst_valid", 32'(O_food_valid), 0);
        check("rst_fail", 32'(O_fail), 0);
        check("rst_tries", 32'(O_tries), 0);
        check("rst_drive", 32'(O_box_drive), 0);
        check("rst_req", 32'(O_occ_req), 0);
        check("rst_occ_x", 32'(O_occ_x), 0);

        // Single-candidate legality table; an illegal one falls through to (64,64)
        for (int i = 0; i < 10; i++) begin
            clear_scenario();
            v_x.push_back(table_v[i].x);
            v_y.push_back(table_v[i].y);
            run_case($sformatf("tbl%0d", i), 1, 0, 0);
            check($sformatf("tbl%0d_x", i), 32'(O_food_x), table_v[i].legal ? table_v[i].x : 64);
            check($sformatf("tbl%0d_n", i), 32'(O_tries), table_v[i].legal ? 1 : 2);
        end

        // Two illegal candidates then a free one
        clear_scenario();
        v_x = '{33, 0, 64}; v_y = '{48, 48, 64};
        run_case("three", 0, 1, 0);
        check("three_tries", 32'(O_tries), 3);

        // Every legal candidate occupied: limit reached
        clear_scenario();
        for (int i = 0; i < 15; i++) begin
            v_x.push_back(16 * (i + 1)); v_y.push_back(32);
            v_hit.push_back(1); v_dly.push_back(i % 3);
        end
        run_case("allhit", 0, 1, 0);
        check("allhit_tries15", 32'(O_tries), 15);
        I_eaten = 1;
        @(negedge I_clk);
        I_eaten = 0;
        @(negedge I_clk);
        check("fail_eaten_busy", 32'(O_busy), 0);
        check("fail_eaten_fail", 32'(O_fail), 1);
        clear_scenario();
        run_case("restart", 1, 0, 0);

        // Both pulses together, eaten poked during a long query
        clear_scenario();
        v_x.push_back(128); v_y.push_back(96);
        v_hit.push_back(0); v_dly.push_back(4);
        run_case("dual", 1, 1, 1);
        check("dual_req_cycles", g_req_cycles, 5);
        repeat (2) @(negedge I_clk);
        check("dual_no_queue", 32'(O_busy), 0);

        // Reset while a query is outstanding, then a late ack
        I_start = 1;
        @(negedge I_clk);
        I_start = 0;
        for (int i = 0; i < 20 && !O_occ_req; i++) begin
            if (O_box_drive) begin I_box_x = 10'd64; I_box_y = 10'd64; end
            @(negedge I_clk);
        end
        check("rq_reached", 32'(O_occ_req), 1);
        I_rst = 1; I_start = 1;
        @(negedge I_clk);
        I_rst = 0; I_start = 0; I_occ_ack = 1; I_occ_hit = 0;
        @(negedge I_clk);
        I_occ_ack = 0;
        begin
            int d = 0, r = 0, b = 0;
            for (int i = 0; i < 5; i++) begin
                d += int'(O_box_drive); r += int'(O_occ_req); b += int'(O_busy);
                @(negedge I_clk);
            end
            check("rq_drive", d, 0);
            check("rq_req", r, 0);
            check("rq_busy", b, 0);
        end
        check("rq_valid", 32'(O_food_valid), 0);
        check("rq_food_x", 32'(O_food_x), 0);
        check("rq_food_y", 32'(O_food_y), 0);
        check("rq_tries", 32'(O_tries), 0);
        check("rq_fail", 32'(O_fail), 0);
        exp_food_x = 0; exp_food_y = 0; in_fail = 0;

        // Randomized placements against the model
        spurious_ack = 1;
        for (int n = 0; n < 40; n++) begin
            bit st, ea;
            clear_scenario();
            for (int i = 0; i < 15; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v_x.push_back($urandom_range(0, 1023));
                    v_y.push_back($urandom_range(0, 1023));
                end else begin
                    v_x.push_back(16 * $urandom_range(1, 38));
                    v_y.push_back(16 * $urandom_range(1, 28));
                end
                v_hit.push_back((n % 10 == 9) ? 1 : int'($urandom_range(0, 2) == 0));
                v_dly.push_back($urandom_range(0, 3));
            end
            if (in_fail) begin
                st = 1; ea = 0;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin st = 1; ea = 0; end
                    1: begin st = 0; ea = 1; end
                    default: begin st = 1; ea = 1; end
                endcase
            end
            run_case($sformatf("rnd%0d", n), st, ea, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
